fetch_unit: RTL and testbench

Sequential instruction fetch stage for the SEQ Y86-64 processor; it is the consumer of the next-PC value produced by the PC-update stage. Given a start PC, it reads instruction bytes one at a time from a byte-wide instruction memory over a req/ack handshake. It decodes the instruction length from icode and assembles icode, ifun, rA, rB, valC and valP. It presents them with a one-cycle valid pulse to decode/execute and back to PC update.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: byte-serial Y86-64 instruction fetch with req/ack memory handshake
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic        start,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_data,
  input  logic        imem_ack,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        instr_invalid,
  output logic        halted,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, BYTE0, REG, CONST, DONE} state_t;
  state_t state;
  logic [63:0] pc;
  logic [3:0] idx;
  logic [2:0] k;
  logic [3:0] op;
  logic [3:0] len;
  logic xfer;
  logic need_reg;
  logic need_const;
  assign xfer = imem_req && imem_ack;
  assign op = imem_data[7:4];
  assign imem_req = state == BYTE0 || state == REG || state == CONST;
  assign imem_addr = pc + 64'(idx);
  assign instr_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    need_reg = op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_const = op inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    len = need_reg ? (need_const ? 4'd10 : 4'd2) : (need_const ? 4'd9 : 4'd1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      idx <= '0;
      k <= '0;
      icode <= '0;
      ifun <= '0;
      rA <= 4'hF;
      rB <= 4'hF;
      valC <= '0;
      valP <= '0;
      instr_invalid <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !halted) begin
          state <= BYTE0;
          pc <= pc_in;
          idx <= '0;
          k <= '0;
          icode <= '0;
          ifun <= '0;
          rA <= 4'hF;
          rB <= 4'hF;
          valC <= '0;
          valP <= '0;
          instr_invalid <= 1'b0;
        end
        BYTE0: if (xfer) begin
          icode <= op;
          ifun <= imem_data[3:0];
          instr_invalid <= op > 4'hB;
          valP <= pc + 64'(len);
          idx <= idx + 4'd1;
          state <= need_reg ? REG : need_const ? CONST : DONE;
        end
        REG: if (xfer) begin
          rA <= imem_data[7:4];
          rB <= imem_data[3:0];
          idx <= idx + 4'd1;
          state <= icode inside {4'h3, 4'h4, 4'h5} ? CONST : DONE;
        end
        CONST: if (xfer) begin
          valC[{k, 3'b000} +: 8] <= imem_data;
          idx <= idx + 4'd1;
          k <= k + 3'd1;
          if (k == 3'd7) state <= DONE;
        end
        DONE: begin
          if (icode == 4'h0) halted <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  logic [63:0] pc_in;
  logic start;
  logic imem_req;
  logic [63:0] imem_addr;
  logic [7:0] imem_data;
  logic imem_ack;
  logic [3:0] icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic instr_valid, instr_invalid, halted, busy;
  logic [7:0] b [10];
  int cmps = 0;
  int errs = 0;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .instr_invalid(instr_invalid), .halted(halted), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmps++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic fetch(input logic [63:0] a, input int n, input int w);
    @(negedge clk);
    start = 1'b1;
    pc_in = a;
    @(negedge clk);
    start = 1'b0;
    chk("req_after_start", 64'(imem_req), 1);
    chk("cleared_valC", valC, 0);
    chk("cleared_rA", 64'(rA), 64'hF);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < w; j++) begin
        chk("addr_wait", imem_addr, a + 64'(i));
        @(negedge clk);
      end
      chk("req", 64'(imem_req), 1);
      chk("addr", imem_addr, a + 64'(i));
      imem_ack = 1'b1;
      imem_data = b[i];
      @(negedge clk);
      imem_ack = 1'b0;
    end
    chk("valid", 64'(instr_valid), 1);
    chk("busy_done", 64'(busy), 1);
    @(negedge clk);
    chk("valid_drop", 64'(instr_valid), 0);
    chk("idle", 64'(busy), 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    pc_in = '0;
    imem_ack = 1'b0;
    imem_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_rA", 64'(rA), 64'hF);
    chk("rst_rB", 64'(rB), 64'hF);
    chk("rst_valP", valP, 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_valid", 64'(instr_valid), 0);
    rst = 1'b0;
    b = '{8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    fetch(64'h0, 1, 0);
    chk("halt_icode", 64'(icode), 0);
    chk("halt_valP", valP, 1);
    chk("halt_halted", 64'(halted), 1);
    chk("halt_rA", 64'(rA), 64'hF);
    @(negedge clk);
    start = 1'b1;
    pc_in = 64'h40;
    @(negedge clk);
    start = 1'b0;
    chk("halt_ignore_req", 64'(imem_req), 0);
    chk("halt_ignore_busy", 64'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("halt_cleared", 64'(halted), 0);
    b = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    fetch(64'h100, 10, 0);
    chk("irm_icode", 64'(icode), 3);
    chk("irm_ifun", 64'(ifun), 0);
    chk("irm_rA", 64'(rA), 64'hF);
    chk("irm_rB", 64'(rB), 3);
    chk("irm_valC", valC, 64'h0123456789ABCDEF);
    chk("irm_valP", valP, 64'h10A);
    chk("irm_invalid", 64'(instr_invalid), 0);
    b = '{8'h80, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0};
    fetch(64'h20, 9, 2);
    chk("call_icode", 64'(icode), 8);
    chk("call_valC", valC, 64'h40);
    chk("call_rA", 64'(rA), 64'hF);
    chk("call_rB", 64'(rB), 64'hF);
    chk("call_valP", valP, 64'h29);
    b = '{8'h60, 8'h23, 0, 0, 0, 0, 0, 0, 0, 0};
    fetch(64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    chk("opq_icode", 64'(icode), 6);
    chk("opq_rA", 64'(rA), 2);
    chk("opq_rB", 64'(rB), 3);
    chk("opq_valC", valC, 0);
    chk("opq_valP", valP, 64'h1);
    b = '{8'hD0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    fetch(64'h55, 1, 0);
    chk("inv_flag", 64'(instr_invalid), 1);
    chk("inv_icode", 64'(icode), 64'hD);
    chk("inv_valP", valP, 64'h56);
    chk("inv_rA", 64'(rA), 64'hF);
    b = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0};
    @(negedge clk);
    start = 1'b1;
    pc_in = 64'h300;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1;
      imem_data = b[i];
      @(negedge clk);
      imem_ack = 1'b0;
    end
    chk("mid_req", 64'(imem_req), 1);
    chk("mid_addr", imem_addr, 64'h304);
    chk("mid_valC", valC, 64'h2211);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 64'(imem_req), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_icode", 64'(icode), 0);
    chk("mid_rst_rA", 64'(rA), 64'hF);
    chk("mid_rst_valC", valC, 0);
    chk("mid_rst_valP", valP, 0);
    chk("mid_rst_addr", imem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    b = '{8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    fetch(64'h10, 1, 0);
    chk("nop_icode", 64'(icode), 1);
    chk("nop_valP", valP, 64'h11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
